fir_macc_seq: RTL
=================

# fir_macc_seq

Sequencer that drives an external `MaccCore`-style multiply-accumulate slice to compute an N-tap FIR filter. It:
- accepts one input sample per frame on a valid/ready stream and stores it in a circular delay line;
- streams (sample, coefficient) pairs into the MACC with correct `sload` alignment;
- captures the accumulator once the MACC pipeline drains and emits a scaled result on an output stream.

It is the driving end of the MACC's `ce`/`sload`/`a`/`b`/`accum_out` interface.

## Interface
- `N_TAPS`, 16: filter length, ≥2.
- `ADW`, 24: sample width; signed; used for both input and output.
- `BDW`, 18: coefficient width; signed.
- `ODW`, 48: accumulator width; must be ≥ ADW+BDW.
- `MACC_LAT`, 3: cycles from presenting a pair to its product being in `macc_accum`.
- `OSHIFT`, 0: arithmetic right shift applied to the accumulator before output.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: async active-high reset.
- `s_tdata` in ADW: input sample.
- `s_tvalid` in 1 / `s_tready` out 1: input handshake.
- `m_tdata` out ADW: filtered sample.
- `m_tvalid` out 1 / `m_tready` in 1: output handshake.
- `coef_wr` in 1: coefficient write strobe.
- `coef_addr` in $clog2(N_TAPS): tap index.
- `coef_data` in BDW: coefficient value.
- `macc_ce` out 1: MACC clock enable.
- `macc_sload` out 1: MACC accumulator reload.
- `macc_a` out ADW: sample to MACC.
- `macc_b` out BDW: coefficient to MACC.
- `macc_accum` in ODW: MACC accumulator output.

## Operation
States:
- **IDLE**
  - `s_tready`=1.
  - On `s_tvalid`, write the sample at `wp`, then go to RUN with tap counter k=0.
- **RUN**, N_TAPS cycles
  - Present `macc_a`=buf[(wp−k) mod N_TAPS] and `macc_b`=coef[k].
  - Tap 0 is the newest sample. The index wraps modulo N_TAPS.
- **WAIT**, MACC_LAT cycles
  - `macc_a`=`macc_b`=0.
  - On the last WAIT cycle, register `macc_accum` into the output path.
- **OUT**
  - `m_tvalid`=1.
  - Hold until `m_tvalid && m_tready`, then return to IDLE.

Datapath rules:
- `macc_sload`=1 only in the second RUN cycle (k=1). The MACC applies sload one cycle after its pair, so this clears the accumulator as tap 0's product is added.
- `macc_ce`=1 in every cycle out of reset. `macc_a`/`macc_b` are 0 in IDLE and OUT.
- `wp` advances by 1 (mod N_TAPS) per accepted sample.
- The delay line is zero after reset, so outputs before N_TAPS inputs use zero history.
- Output = `macc_accum` >>> OSHIFT, reduced to ADW bits (see Configuration).

Coefficient writes:
- Written only in IDLE when `coef_wr`=1.
- Writes in any other state are dropped.
- If `coef_wr` and an input accept coincide in IDLE, both take effect. The new coefficient is used by that frame.

Reset, asynchronous, any state:
- Go to IDLE.
- Clear `wp`, the delay line and all coefficients.
- Outputs: `s_tready`=0 while `rst` is high, then 1 in IDLE; `m_tvalid`=0; `m_tdata`=0; `macc_ce`=0; `macc_sload`=0; `macc_a`=0; `macc_b`=0.

## Timing
- Input accepted at edge e:
  - RUN occupies cycles e..e+N_TAPS−1.
  - `macc_sload` is high in cycle e+1.
  - `m_tvalid` rises in cycle e+N_TAPS+MACC_LAT.
- Minimum frame period is N_TAPS+MACC_LAT+2 cycles: the accept cycle in IDLE, RUN, WAIT, and one OUT cycle when `m_tready`=1.
- `s_tready` is combinationally high only in IDLE. There is no input buffering.
- `m_tdata` is registered and stable while `m_tvalid`=1 and `m_tready`=0.

## Configuration
Macro `FIR_MACC_SEQ_SAT_EN`:
- **Defined:** the shifted accumulator saturates to [−2^(ADW−1), 2^(ADW−1)−1].
- **Undefined:** the low ADW bits are taken (two's-complement wrap).

## Structure
- Shared package `fir_macc_pkg`:
  - `state_t` enum {IDLE, RUN, WAIT, OUT};
  - saturation function `sat_trunc(ODW→ADW)`;
  - default width constants.
- The delay line plus coefficient store is a natural sub-module, `fir_tap_store`: a circular sample buffer with write pointer, and a coefficient register file with read index.
- The MACC is instantiated outside this block.

## Test plan
All scenarios use N_TAPS=4, a bench `MaccCore` with MACC_LAT=3, OSHIFT=0, and `m_tready`=1 unless stated.
1. **Impulse response.** Coefs 1,2,3,4; inputs 1,0,0,0,0 → outputs 1,2,3,4,0.
2. **Latency.** Accept at edge e → `macc_sload` high only in cycle e+1; `m_tvalid` first high in cycle e+7; next `s_tready` at e+8.
3. **Backpressure.** Hold `m_tready`=0 for 10 cycles → `m_tdata` stable, `s_tready`=0 throughout; one transfer when released.
4. **Saturation.** Coefs all 131071; four inputs of 8388607 → fourth output is 8388607 with the macro defined, and the low 24 bits of 4·131071·8388607 without it.
5. **Reset mid-RUN.** Assert `rst` during tap 2 → outputs at reset values immediately; after release, input 5 with coefs rewritten to 1,0,0,0 → output 5.
6. **Dropped write.** `coef_wr` during RUN with addr 0, data 9 → ignored; the next frame uses the prior coefficient.

Source files
------------

// File: rtl/fir_macc_pkg.sv
// Shared types, default widths and output saturation helper for the FIR MACC sequencer.
package fir_macc_pkg;

    typedef enum logic [1:0] {IDLE, RUN, WAIT, OUT} state_t;

    localparam int N_TAPS_DEF   = 16;
    localparam int ADW_DEF      = 24;
    localparam int BDW_DEF      = 18;
    localparam int ODW_DEF      = 48;
    localparam int MACC_LAT_DEF = 3;
    localparam int OSHIFT_DEF   = 0;
    localparam int SAT_W        = 64;

    // Clamp a sign-extended accumulator into the signed range of an ow-bit result.
    function automatic logic signed [SAT_W-1:0] sat_trunc(input logic signed [SAT_W-1:0] v,
                                                          input int unsigned ow);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (ow - 1)) - SAT_W'(1);
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/fir_tap_store.sv
// Circular sample delay line with write pointer plus coefficient register file.
module fir_tap_store
    import fir_macc_pkg::*;
#(
    parameter int N_TAPS = N_TAPS_DEF,
    parameter int ADW    = ADW_DEF,
    parameter int BDW    = BDW_DEF,
    localparam int AW    = $clog2(N_TAPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  samp_we_i,
    input  logic signed [ADW-1:0] samp_wdata_i,
    input  logic                  wp_adv_i,
    input  logic        [AW-1:0]  rd_k_i,
    input  logic                  coef_we_i,
    input  logic        [AW-1:0]  coef_addr_i,
    input  logic signed [BDW-1:0] coef_wdata_i,
    output logic signed [ADW-1:0] samp_o,
    output logic signed [BDW-1:0] coef_o
);

    logic signed [ADW-1:0] samp_q [N_TAPS];
    logic signed [BDW-1:0] coef_q [N_TAPS];
    logic        [AW-1:0]  wp_q;
    logic        [AW-1:0]  wp_d;
    logic        [AW-1:0]  rd_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            for (int i = 0; i < N_TAPS; i++) begin
                samp_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            wp_q <= wp_d;
            if (samp_we_i) begin
                samp_q[wp_q] <= samp_wdata_i;
            end
            if (coef_we_i) begin
                coef_q[coef_addr_i] <= coef_wdata_i;
            end
        end
    end

    always_comb begin
        wp_d = wp_q;
        if (wp_adv_i) begin
            wp_d = (wp_q == AW'(N_TAPS - 1)) ? '0 : wp_q + AW'(1);
        end
    end

    // Tap k reads k samples behind the newest one, wrapping modulo N_TAPS.
    always_comb begin
        if (rd_k_i > wp_q) begin
            rd_idx = wp_q + AW'(N_TAPS) - rd_k_i;
        end else begin
            rd_idx = wp_q - rd_k_i;
        end
    end

    assign samp_o = samp_q[rd_idx];
    assign coef_o = coef_q[rd_k_i];

endmodule

// File: rtl/fir_macc_seq.sv
// FIR sequencer driving an external MACC slice; define FIR_MACC_SEQ_SAT_EN to
// saturate the output instead of wrapping it.
module fir_macc_seq
    import fir_macc_pkg::*;
#(
    parameter int N_TAPS   = N_TAPS_DEF,
    parameter int ADW      = ADW_DEF,
    parameter int BDW      = BDW_DEF,
    parameter int ODW      = ODW_DEF,
    parameter int MACC_LAT = MACC_LAT_DEF,
    parameter int OSHIFT   = OSHIFT_DEF,
    localparam int AW      = $clog2(N_TAPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [ADW-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic signed [ADW-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    input  logic                  coef_wr,
    input  logic        [AW-1:0]  coef_addr,
    input  logic signed [BDW-1:0] coef_data,
    output logic                  macc_ce,
    output logic                  macc_sload,
    output logic signed [ADW-1:0] macc_a,
    output logic signed [BDW-1:0] macc_b,
    input  logic signed [ODW-1:0] macc_accum
);

    localparam int WW = (MACC_LAT > 1) ? $clog2(MACC_LAT) : 1;

    state_t                state_q, state_d;
    logic        [AW-1:0]  k_q, k_d;
    logic        [WW-1:0]  w_q, w_d;
    logic signed [ADW-1:0] m_tdata_q, m_tdata_d;
    logic signed [ADW-1:0] tap_samp;
    logic signed [BDW-1:0] tap_coef;
    logic                  accept;
    logic                  last_tap;
    logic signed [ADW-1:0] result;

    assign accept   = s_tready && s_tvalid;
    assign last_tap = (state_q == RUN) && (k_q == AW'(N_TAPS - 1));

    fir_tap_store #(
        .N_TAPS (N_TAPS),
        .ADW    (ADW),
        .BDW    (BDW)
    ) u_store (
        .clk          (clk),
        .rst          (rst),
        .samp_we_i    (accept),
        .samp_wdata_i (s_tdata),
        .wp_adv_i     (last_tap),
        .rd_k_i       (k_q),
        .coef_we_i    ((state_q == IDLE) && coef_wr),
        .coef_addr_i  (coef_addr),
        .coef_wdata_i (coef_data),
        .samp_o       (tap_samp),
        .coef_o       (tap_coef)
    );

`ifdef FIR_MACC_SEQ_SAT_EN
    logic signed [SAT_W-1:0] acc_ext;
    assign acc_ext = SAT_W'(macc_accum >>> OSHIFT);
    assign result  = ADW'(sat_trunc(acc_ext, ADW));
`else
    assign result  = ADW'(macc_accum >>> OSHIFT);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            w_q       <= '0;
            m_tdata_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            w_q       <= w_d;
            m_tdata_q <= m_tdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        w_d       = w_q;
        m_tdata_d = m_tdata_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    k_d     = '0;
                end
            end
            RUN: begin
                k_d = k_q + AW'(1);
                if (last_tap) begin
                    state_d = WAIT;
                    k_d     = '0;
                    w_d     = '0;
                end
            end
            WAIT: begin
                w_d = w_q + WW'(1);
                // The last product has just landed in the accumulator.
                if (w_q == WW'(MACC_LAT - 1)) begin
                    state_d   = OUT;
                    m_tdata_d = result;
                end
            end
            OUT: begin
                if (m_tready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_tready   = (state_q == IDLE) && !rst;
    assign m_tvalid   = (state_q == OUT);
    assign m_tdata    = m_tdata_q;
    assign macc_ce    = !rst;
    // The MACC applies sload one cycle late, so it lines up with tap 0's product.
    assign macc_sload = (state_q == RUN) && (k_q == AW'(1));
    assign macc_a     = (state_q == RUN) ? tap_samp : '0;
    assign macc_b     = (state_q == RUN) ? tap_coef : '0;

endmodule
